// File: rtl/raster_line_sched.sv
// rtl/raster_line_sched.sv - per-line/per-frame raster parameter scheduler (optional RASTER_SCHED_CLAMP_EN saturating step)
module raster_line_sched #(
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE       = 480,
    parameter int LAST_STEP_LINE = 478
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_tri_color,
    input  logic [19:0] in_yv0,
    input  logic [19:0] in_yv1,
    input  logic [19:0] in_yv2,
    input  logic [19:0] in_e0_row0,
    input  logic [19:0] in_e1_row0,
    input  logic [19:0] in_e2_row0,
    input  logic [19:0] in_e0_dy,
    input  logic [19:0] in_e1_dy,
    input  logic [19:0] in_e2_dy,
    input  logic [21:0] in_iy_row0,
    input  logic [21:0] in_iz_row0,
    input  logic [21:0] in_iy_dy,
    input  logic [21:0] in_iz_dy,
    input  logic [21:0] in_iy_dx,
    input  logic [21:0] in_iz_dx,
    output logic [2:0]  tri_color,
    output logic [19:0] y_screen_v0,
    output logic [19:0] y_screen_v1,
    output logic [19:0] y_screen_v2,
    output logic [19:0] e0_init_t1,
    output logic [19:0] e1_init_t1,
    output logic [19:0] e2_init_t1,
    output logic [21:0] bar_iy,
    output logic [21:0] bar_iz,
    output logic [21:0] bar_iy_dx,
    output logic [21:0] bar_iz_dx,
    output logic        commit
);

    localparam logic [9:0] H_COL     = 10'(H_ACTIVE);
    localparam logic [9:0] V_LINE    = 10'(V_ACTIVE);
    localparam logic [9:0] LAST_LINE = 10'(LAST_STEP_LINE);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STEP   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]  state;
    logic [2:0]  step_idx;
    logic        pending;
    logic        capture;

    logic [2:0]  sh_color;
    logic [19:0] sh_yv0, sh_yv1, sh_yv2;
    logic [19:0] sh_e0_row0, sh_e1_row0, sh_e2_row0;
    logic [19:0] sh_e0_dy, sh_e1_dy, sh_e2_dy;
    logic [21:0] sh_iy_row0, sh_iz_row0, sh_iy_dy, sh_iz_dy, sh_iy_dx, sh_iz_dx;

    logic [19:0] act_e0_row0, act_e1_row0, act_e2_row0;
    logic [19:0] act_e0_dy, act_e1_dy, act_e2_dy;
    logic [21:0] act_iy_row0, act_iz_row0, act_iy_dy, act_iz_dy;

    logic [21:0] op_a, op_b;
    logic [19:0] edge_sum;
    logic [21:0] bar_sum;

    assign in_ready = !pending;
    assign capture  = in_valid && !pending;
    assign commit   = (state == S_COMMIT);

    // One shared adder; the step index picks which output/increment pair it serves.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (step_idx)
            3'd0: begin op_a = {{2{e0_init_t1[19]}}, e0_init_t1}; op_b = {{2{act_e0_dy[19]}}, act_e0_dy}; end
            3'd1: begin op_a = {{2{e1_init_t1[19]}}, e1_init_t1}; op_b = {{2{act_e1_dy[19]}}, act_e1_dy}; end
            3'd2: begin op_a = {{2{e2_init_t1[19]}}, e2_init_t1}; op_b = {{2{act_e2_dy[19]}}, act_e2_dy}; end
            3'd3: begin op_a = bar_iy; op_b = act_iy_dy; end
            3'd4: begin op_a = bar_iz; op_b = act_iz_dy; end
            default: ;
        endcase
    end

`ifdef RASTER_SCHED_CLAMP_EN
    logic signed [22:0] sum_wide;
    assign sum_wide = $signed({op_a[21], op_a}) + $signed({op_b[21], op_b});

    always_comb begin
        if (sum_wide > 23'sd524287)        edge_sum = 20'h7FFFF;
        else if (sum_wide < -23'sd524288)  edge_sum = 20'h80000;
        else                               edge_sum = sum_wide[19:0];
        if (sum_wide > 23'sd2097151)       bar_sum = 22'h1FFFFF;
        else if (sum_wide < -23'sd2097152) bar_sum = 22'h200000;
        else                               bar_sum = sum_wide[21:0];
    end
`else
    logic [21:0] sum_wrap;
    assign sum_wrap = op_a + op_b;
    assign edge_sum = sum_wrap[19:0];
    assign bar_sum  = sum_wrap;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            step_idx <= 3'd0;
            pending  <= 1'b0;
            sh_color <= '0;
            sh_yv0 <= '0; sh_yv1 <= '0; sh_yv2 <= '0;
            sh_e0_row0 <= '0; sh_e1_row0 <= '0; sh_e2_row0 <= '0;
            sh_e0_dy <= '0; sh_e1_dy <= '0; sh_e2_dy <= '0;
            sh_iy_row0 <= '0; sh_iz_row0 <= '0; sh_iy_dy <= '0; sh_iz_dy <= '0;
            sh_iy_dx <= '0; sh_iz_dx <= '0;
            act_e0_row0 <= '0; act_e1_row0 <= '0; act_e2_row0 <= '0;
            act_e0_dy <= '0; act_e1_dy <= '0; act_e2_dy <= '0;
            act_iy_row0 <= '0; act_iz_row0 <= '0; act_iy_dy <= '0; act_iz_dy <= '0;
            tri_color <= '0;
            y_screen_v0 <= '0; y_screen_v1 <= '0; y_screen_v2 <= '0;
            e0_init_t1 <= '0; e1_init_t1 <= '0; e2_init_t1 <= '0;
            bar_iy <= '0; bar_iz <= '0; bar_iy_dx <= '0; bar_iz_dx <= '0;
        end else begin
            if (capture) begin
                pending    <= 1'b1;
                sh_color   <= in_tri_color;
                sh_yv0     <= in_yv0;     sh_yv1 <= in_yv1;         sh_yv2 <= in_yv2;
                sh_e0_row0 <= in_e0_row0; sh_e1_row0 <= in_e1_row0; sh_e2_row0 <= in_e2_row0;
                sh_e0_dy   <= in_e0_dy;   sh_e1_dy <= in_e1_dy;     sh_e2_dy <= in_e2_dy;
                sh_iy_row0 <= in_iy_row0; sh_iz_row0 <= in_iz_row0;
                sh_iy_dy   <= in_iy_dy;   sh_iz_dy <= in_iz_dy;
                sh_iy_dx   <= in_iy_dx;   sh_iz_dx <= in_iz_dx;
            end

            case (state)
                S_IDLE: begin
                    if (y == V_LINE && x == H_COL) begin
                        state <= S_COMMIT;
                    end else if (y <= LAST_LINE && x == H_COL) begin
                        state    <= S_STEP;
                        step_idx <= 3'd0;
                    end
                end
                S_STEP: begin
                    case (step_idx)
                        3'd0:    e0_init_t1 <= edge_sum;
                        3'd1:    e1_init_t1 <= edge_sum;
                        3'd2:    e2_init_t1 <= edge_sum;
                        3'd3:    bar_iy     <= bar_sum;
                        default: bar_iz     <= bar_sum;
                    endcase
                    if (step_idx == 3'd4) state <= S_IDLE;
                    else                  step_idx <= step_idx + 3'd1;
                end
                S_COMMIT: begin
                    // Without a pending upload the active set is kept and row0 is replayed.
                    if (pending) begin
                        pending     <= 1'b0;
                        act_e0_row0 <= sh_e0_row0; act_e1_row0 <= sh_e1_row0; act_e2_row0 <= sh_e2_row0;
                        act_e0_dy   <= sh_e0_dy;   act_e1_dy <= sh_e1_dy;     act_e2_dy <= sh_e2_dy;
                        act_iy_row0 <= sh_iy_row0; act_iz_row0 <= sh_iz_row0;
                        act_iy_dy   <= sh_iy_dy;   act_iz_dy <= sh_iz_dy;
                        tri_color   <= sh_color;
                        y_screen_v0 <= sh_yv0;     y_screen_v1 <= sh_yv1;     y_screen_v2 <= sh_yv2;
                        e0_init_t1  <= sh_e0_row0; e1_init_t1 <= sh_e1_row0;  e2_init_t1 <= sh_e2_row0;
                        bar_iy      <= sh_iy_row0; bar_iz <= sh_iz_row0;
                        bar_iy_dx   <= sh_iy_dx;   bar_iz_dx <= sh_iz_dx;
                    end else begin
                        e0_init_t1  <= act_e0_row0; e1_init_t1 <= act_e1_row0; e2_init_t1 <= act_e2_row0;
                        bar_iy      <= act_iy_row0; bar_iz <= act_iz_row0;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_line_sched.sv
// tb/tb_raster_line_sched.sv - directed self-checking bench for raster_line_sched
module tb_raster_line_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  x = '0, y = 10'd500;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_tri_color = '0;
    logic [19:0] in_yv0 = '0, in_yv1 = '0, in_yv2 = '0;
    logic [19:0] in_e0_row0 = '0, in_e1_row0 = '0, in_e2_row0 = '0;
    logic [19:0] in_e0_dy = '0, in_e1_dy = '0, in_e2_dy = '0;
    logic [21:0] in_iy_row0 = '0, in_iz_row0 = '0, in_iy_dy = '0, in_iz_dy = '0;
    logic [21:0] in_iy_dx = '0, in_iz_dx = '0;
    logic [2:0]  tri_color;
    logic [19:0] y_screen_v0, y_screen_v1, y_screen_v2;
    logic [19:0] e0_init_t1, e1_init_t1, e2_init_t1;
    logic [21:0] bar_iy, bar_iz, bar_iy_dx, bar_iz_dx;
    logic        commit;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    raster_line_sched dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_tri_color(in_tri_color),
        .in_yv0(in_yv0), .in_yv1(in_yv1), .in_yv2(in_yv2),
        .in_e0_row0(in_e0_row0), .in_e1_row0(in_e1_row0), .in_e2_row0(in_e2_row0),
        .in_e0_dy(in_e0_dy), .in_e1_dy(in_e1_dy), .in_e2_dy(in_e2_dy),
        .in_iy_row0(in_iy_row0), .in_iz_row0(in_iz_row0),
        .in_iy_dy(in_iy_dy), .in_iz_dy(in_iz_dy),
        .in_iy_dx(in_iy_dx), .in_iz_dx(in_iz_dx),
        .tri_color(tri_color),
        .y_screen_v0(y_screen_v0), .y_screen_v1(y_screen_v1), .y_screen_v2(y_screen_v2),
        .e0_init_t1(e0_init_t1), .e1_init_t1(e1_init_t1), .e2_init_t1(e2_init_t1),
        .bar_iy(bar_iy), .bar_iz(bar_iz), .bar_iy_dx(bar_iy_dx), .bar_iz_dx(bar_iz_dx),
        .commit(commit)
    );

    task automatic set_xy(input logic [9:0] yy, input logic [9:0] xx);
        @(negedge clk);
        y = yy;
        x = xx;
    endtask

    task automatic do_line(input int yy);
        for (int xx = 638; xx <= 647; xx++) set_xy(10'(yy), 10'(xx));
        set_xy(10'(yy), 10'd799);
    endtask

    task automatic do_commit(input string tag);
        set_xy(10'd480, 10'd639);
        set_xy(10'd480, 10'd640);
        set_xy(10'd480, 10'd641);
        total++; if (commit !== 1'b1) begin bad++; $display("FAIL %s_commit_pulse got=%b exp=1", tag, commit); end
        set_xy(10'd480, 10'd642);
        total++; if (commit !== 1'b0) begin bad++; $display("FAIL %s_commit_end got=%b exp=0", tag, commit); end
    endtask

    task automatic load_word(input logic [2:0] c,
                             input logic [19:0] e0r, e0d, e1r, e1d, e2r, e2d,
                             input logic [21:0] iyr, iyd, iyx, izr, izd, izx);
        in_tri_color = c;
        in_yv0 = 20'd10 + 20'(c); in_yv1 = 20'd20 + 20'(c); in_yv2 = 20'd30 + 20'(c);
        in_e0_row0 = e0r; in_e0_dy = e0d;
        in_e1_row0 = e1r; in_e1_dy = e1d;
        in_e2_row0 = e2r; in_e2_dy = e2d;
        in_iy_row0 = iyr; in_iy_dy = iyd; in_iy_dx = iyx;
        in_iz_row0 = izr; in_iz_dy = izd; in_iz_dx = izx;
    endtask

    task automatic upload(input string tag);
        set_xy(10'd500, 10'd0);
        in_valid = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_before got=%b exp=1", tag, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL %s_ready_after got=%b exp=0", tag, in_ready); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        total++; if (commit !== 1'b0) begin bad++; $display("FAIL reset_commit got=%b exp=0", commit); end
        total++;
        if ({tri_color, y_screen_v0, y_screen_v1, y_screen_v2, e0_init_t1, e1_init_t1, e2_init_t1,
             bar_iy, bar_iz, bar_iy_dx, bar_iz_dx} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", {e0_init_t1, bar_iy});
        end
        rst_n = 1'b1;
        do_line(0);
        do_line(1);
        total++; if ({e0_init_t1, bar_iy} !== '0) begin bad++; $display("FAIL reset_hold got=%h exp=0", {e0_init_t1, bar_iy}); end
    endtask

    task automatic test_upload_commit;
        load_word(3'd5, 20'(-100), 20'd3, 20'd50, 20'(-2), 20'd1000, 20'(-7),
                  22'h40000, 22'h100, 22'h10, 22'h80000, 22'h3FFE00, 22'h3FFFF0);
        upload("up");
        do_commit("up");
        total++; if (e0_init_t1 !== 20'(-100)) begin bad++; $display("FAIL up_e0 got=%0d exp=-100", $signed(e0_init_t1)); end
        total++; if (e2_init_t1 !== 20'd1000) begin bad++; $display("FAIL up_e2 got=%0d exp=1000", $signed(e2_init_t1)); end
        total++; if (bar_iy !== 22'h40000) begin bad++; $display("FAIL up_bar_iy got=%h exp=40000", bar_iy); end
        total++; if (bar_iz !== 22'h80000) begin bad++; $display("FAIL up_bar_iz got=%h exp=80000", bar_iz); end
        total++; if (bar_iy_dx !== 22'h10) begin bad++; $display("FAIL up_iy_dx got=%h exp=10", bar_iy_dx); end
        total++; if (bar_iz_dx !== 22'h3FFFF0) begin bad++; $display("FAIL up_iz_dx got=%h exp=3ffff0", bar_iz_dx); end
        total++; if (tri_color !== 3'd5) begin bad++; $display("FAIL up_color got=%0d exp=5", tri_color); end
        total++; if (y_screen_v1 !== 20'd25) begin bad++; $display("FAIL up_yv1 got=%0d exp=25", y_screen_v1); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL up_ready_after_commit got=%b exp=1", in_ready); end
    endtask

    task automatic test_line_step;
        do_line(0);
        do_line(1);
        total++; if (e0_init_t1 !== 20'(-94)) begin bad++; $display("FAIL step_y1_e0 got=%0d exp=-94", $signed(e0_init_t1)); end
        total++; if (e1_init_t1 !== 20'd46) begin bad++; $display("FAIL step_y1_e1 got=%0d exp=46", $signed(e1_init_t1)); end
        total++; if (e2_init_t1 !== 20'd986) begin bad++; $display("FAIL step_y1_e2 got=%0d exp=986", $signed(e2_init_t1)); end
        total++; if (bar_iy !== 22'h40200) begin bad++; $display("FAIL step_y1_iy got=%h exp=40200", bar_iy); end
        total++; if (bar_iz !== 22'h7FC00) begin bad++; $display("FAIL step_y1_iz got=%h exp=7fc00", bar_iz); end
        for (int l = 2; l <= 479; l++) do_line(l);
        total++; if (e0_init_t1 !== 20'd1337) begin bad++; $display("FAIL step_y479_e0 got=%0d exp=1337", $signed(e0_init_t1)); end
        total++; if (e1_init_t1 !== 20'(-908)) begin bad++; $display("FAIL step_y479_e1 got=%0d exp=-908", $signed(e1_init_t1)); end
        total++; if (e2_init_t1 !== 20'(-2353)) begin bad++; $display("FAIL step_y479_e2 got=%0d exp=-2353", $signed(e2_init_t1)); end
        total++; if (bar_iy !== 22'h5DF00) begin bad++; $display("FAIL step_y479_iy got=%h exp=5df00", bar_iy); end
        total++; if (bar_iz !== 22'h44200) begin bad++; $display("FAIL step_y479_iz got=%h exp=44200", bar_iz); end
        set_xy(10'd480, 10'd0);
        set_xy(10'd480, 10'd639);
        total++; if (e0_init_t1 !== 20'd1337) begin bad++; $display("FAIL step_vblank_hold got=%0d exp=1337", $signed(e0_init_t1)); end
    endtask

    task automatic test_no_pending;
        do_commit("rep");
        total++; if (e0_init_t1 !== 20'(-100)) begin bad++; $display("FAIL rep_e0 got=%0d exp=-100", $signed(e0_init_t1)); end
        total++; if (bar_iz !== 22'h80000) begin bad++; $display("FAIL rep_bar_iz got=%h exp=80000", bar_iz); end
        total++; if (tri_color !== 3'd5) begin bad++; $display("FAIL rep_color got=%0d exp=5", tri_color); end
    endtask

    task automatic test_back_to_back;
        load_word(3'd3, 20'd200, 20'd1, 20'd0, 20'd0, 20'd0, 20'd0,
                  22'h1000, 22'h0, 22'h20, 22'h2000, 22'h0, 22'h30);
        upload("bp_b");
        load_word(3'd6, 20'(-5), 20'd2, 20'd7, 20'd0, 20'd0, 20'd0,
                  22'h3000, 22'h0, 22'h40, 22'h0, 22'h0, 22'h0);
        in_valid = 1'b1;
        set_xy(10'd480, 10'd639);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_held got=%b exp=0", in_ready); end
        set_xy(10'd480, 10'd640);
        set_xy(10'd480, 10'd641);
        total++; if (commit !== 1'b1) begin bad++; $display("FAIL bp_commit got=%b exp=1", commit); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_commit got=%b exp=0", in_ready); end
        set_xy(10'd480, 10'd642);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_open got=%b exp=1", in_ready); end
        total++; if (e0_init_t1 !== 20'd200) begin bad++; $display("FAIL bp_b_e0 got=%0d exp=200", $signed(e0_init_t1)); end
        total++; if (bar_iy_dx !== 22'h20) begin bad++; $display("FAIL bp_b_iy_dx got=%h exp=20", bar_iy_dx); end
        set_xy(10'd480, 10'd643);
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_c_captured got=%b exp=0", in_ready); end
        total++; if (tri_color !== 3'd3) begin bad++; $display("FAIL bp_b_color_kept got=%0d exp=3", tri_color); end
        do_commit("bp_c");
        total++; if (e0_init_t1 !== 20'(-5)) begin bad++; $display("FAIL bp_c_e0 got=%0d exp=-5", $signed(e0_init_t1)); end
        total++; if (bar_iy !== 22'h3000) begin bad++; $display("FAIL bp_c_iy got=%h exp=3000", bar_iy); end
        total++; if (tri_color !== 3'd6) begin bad++; $display("FAIL bp_c_color got=%0d exp=6", tri_color); end
    endtask

    task automatic test_overflow;
        logic [19:0] exp_e0, exp_e1;
        logic [21:0] exp_iy, exp_iz;
`ifdef RASTER_SCHED_CLAMP_EN
        exp_e0 = 20'h7FFFF; exp_e1 = 20'h80000; exp_iy = 22'h1FFFFF; exp_iz = 22'h200000;
`else
        exp_e0 = 20'h80000; exp_e1 = 20'h7FFFF; exp_iy = 22'h200000; exp_iz = 22'h1FFFFF;
`endif
        load_word(3'd1, 20'h7FFFF, 20'd1, 20'h80000, 20'hFFFFF, 20'd0, 20'd0,
                  22'h1FFFFF, 22'h1, 22'h0, 22'h200000, 22'h3FFFFF, 22'h0);
        upload("ovf");
        do_commit("ovf");
        do_line(0);
        total++; if (e0_init_t1 !== exp_e0) begin bad++; $display("FAIL ovf_e0 got=%h exp=%h", e0_init_t1, exp_e0); end
        total++; if (e1_init_t1 !== exp_e1) begin bad++; $display("FAIL ovf_e1 got=%h exp=%h", e1_init_t1, exp_e1); end
        total++; if (bar_iy !== exp_iy) begin bad++; $display("FAIL ovf_iy got=%h exp=%h", bar_iy, exp_iy); end
        total++; if (bar_iz !== exp_iz) begin bad++; $display("FAIL ovf_iz got=%h exp=%h", bar_iz, exp_iz); end
        set_xy(10'd1, 10'd639);
        set_xy(10'd1, 10'd641);
        for (int xx = 642; xx <= 650; xx++) set_xy(10'd1, 10'(xx));
        set_xy(10'd1, 10'd799);
        total++; if (e0_init_t1 !== exp_e0) begin bad++; $display("FAIL missed_trigger got=%h exp=%h", e0_init_t1, exp_e0); end
    endtask

    task automatic test_reset_mid_step;
        load_word(3'd2, 20'd77, 20'd1, 20'd0, 20'd0, 20'd0, 20'd0,
                  22'h77, 22'h1, 22'h0, 22'h0, 22'h0, 22'h0);
        upload("rst");
        set_xy(10'd10, 10'd640);
        set_xy(10'd10, 10'd641);
        set_xy(10'd10, 10'd642);
        #2 rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_async_ready got=%b exp=1", in_ready); end
        total++;
        if ({tri_color, y_screen_v0, e0_init_t1, e1_init_t1, e2_init_t1, bar_iy, bar_iz, bar_iy_dx} !== '0) begin
            bad++; $display("FAIL rst_async_outputs got=%h exp=0", {e0_init_t1, bar_iy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_line(10);
        do_line(11);
        total++; if ({e0_init_t1, bar_iy} !== '0) begin bad++; $display("FAIL rst_hold got=%h exp=0", {e0_init_t1, bar_iy}); end
        do_commit("rst");
        total++; if ({tri_color, e0_init_t1, bar_iy} !== '0) begin bad++; $display("FAIL rst_commit_zero got=%h exp=0", {e0_init_t1, bar_iy}); end
    endtask

    initial begin
        test_reset();
        test_upload_commit();
        test_line_step();
        test_no_pending();
        test_back_to_back();
        test_overflow();
        test_reset_mid_step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
